// File: rtl/exec_writeback_scheduler.sv
// Writeback slot pipeline between the SPU execute stage and the register-file write port.
// Optional macro WB_FLUSH_EN adds a flush input that invalidates every in-flight result.
module exec_writeback_scheduler #(
    parameter int MAX_LAT    = 7,
    parameter int REG_ADDR_W = 7,
    parameter int DATA_W     = 128,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef WB_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic [2:0]            issue_latency,
    input  logic [DATA_W-1:0]     issue_result,
    input  logic [REG_ADDR_W-1:0] issue_ra,
    input  logic [REG_ADDR_W-1:0] issue_rb,
    input  logic [REG_ADDR_W-1:0] issue_rc,
    input  logic                  issue_ra_used,
    input  logic                  issue_rb_used,
    input  logic                  issue_rc_used,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rt,
    output logic [DATA_W-1:0]     wb_data,
    output logic [3:0]            inflight,
    output logic [CNT_W-1:0]      stall_cycles
);
    localparam int DEPTH = MAX_LAT + 1;
    localparam int LW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rt;
        logic [DATA_W-1:0]     data;
    } slot_t;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [3:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic          flush_w;
    logic [LW-1:0] lat_eff;
    logic          port_conflict, raw, waw, accept, stall;

`ifdef WB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Hazard detection looks at every valid slot, slot 0 included: the
    // register file is read before that same-cycle write lands.
    always_comb begin
        lat_eff       = (int'(issue_latency) > MAX_LAT) ? LW'(MAX_LAT) : LW'(issue_latency);
        port_conflict = 1'b0;
        raw           = 1'b0;
        waw           = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++)
            if (int'(lat_eff) == i && slot_q[i+1].valid) port_conflict = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_q[i].valid) begin
                if (issue_ra_used && issue_ra == slot_q[i].rt) raw = 1'b1;
                if (issue_rb_used && issue_rb == slot_q[i].rt) raw = 1'b1;
                if (issue_rc_used && issue_rc == slot_q[i].rt) raw = 1'b1;
                if (issue_rt == slot_q[i].rt) waw = 1'b1;
            end
        end
    end

    assign issue_ready = !(port_conflict || raw || waw || flush_w);
    assign accept      = issue_valid && issue_ready;
    assign stall       = issue_valid && !issue_ready && !flush_w;

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
        slot_d[DEPTH-1] = '0;
        if (accept) begin
            slot_d[lat_eff].valid = 1'b1;
            slot_d[lat_eff].rt    = issue_rt;
            slot_d[lat_eff].data  = issue_result;
        end
        if (flush_w)
            for (int i = 0; i < DEPTH; i++) slot_d[i].valid = 1'b0;

        inflight_d = '0;
        for (int i = 0; i < DEPTH; i++) inflight_d = inflight_d + 4'(slot_d[i].valid);

        stall_d = stall_q;
        if (stall && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            inflight_q <= '0;
            stall_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
        end
    end

    assign wb_en        = slot_q[0].valid;
    assign wb_rt        = slot_q[0].rt;
    assign wb_data      = slot_q[0].data;
    assign inflight     = inflight_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_exec_writeback_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a booking-list model
// where each accepted result owns the write port in cycle issue+L+1.
module tb_exec_writeback_scheduler;
    localparam int MAX_LAT = 7;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic         clk, reset, flush_tb;
    logic         issue_valid, issue_ready;
    logic [6:0]   issue_rt, issue_ra, issue_rb, issue_rc;
    logic [2:0]   issue_latency;
    logic [127:0] issue_result;
    logic         issue_ra_used, issue_rb_used, issue_rc_used;
    logic         wb_en;
    logic [6:0]   wb_rt;
    logic [127:0] wb_data;
    logic [3:0]   inflight;
    logic [CNT_W-1:0] stall_cycles;

    exec_writeback_scheduler #(.MAX_LAT(MAX_LAT), .REG_ADDR_W(7), .DATA_W(128), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
`ifdef WB_FLUSH_EN
        .flush(flush_tb),
`endif
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rt(issue_rt),
        .issue_latency(issue_latency), .issue_result(issue_result),
        .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc),
        .issue_ra_used(issue_ra_used), .issue_rb_used(issue_rb_used), .issue_rc_used(issue_rc_used),
        .wb_en(wb_en), .wb_rt(wb_rt), .wb_data(wb_data),
        .inflight(inflight), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: list of booked writebacks, each with its due cycle.
    typedef struct { logic [6:0] rt; logic [127:0] data; int due; } ent_t;
    ent_t pend[$];
    int   cyc = 0;
    int   m_stall = 0;

    function automatic int eff_lat();
        return (int'(issue_latency) > MAX_LAT) ? MAX_LAT : int'(issue_latency);
    endfunction

    function automatic bit m_ready();
        int l = eff_lat();
        if (flush_tb) return 1'b0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc + l + 1) return 1'b0;
            if (pend[i].rt == issue_rt) return 1'b0;
            if (issue_ra_used && pend[i].rt == issue_ra) return 1'b0;
            if (issue_rb_used && pend[i].rt == issue_rb) return 1'b0;
            if (issue_rc_used && pend[i].rt == issue_rc) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_wb(output bit en, output logic [6:0] rt, output logic [127:0] d);
        en = 1'b0; rt = '0; d = '0;
        foreach (pend[i]) if (pend[i].due == cyc) begin en = 1'b1; rt = pend[i].rt; d = pend[i].data; end
    endfunction

    task automatic tick();
        bit   rdy = m_ready();
        int   l = eff_lat();
        ent_t e;
        @(posedge clk);
        if (reset) begin
            pend.delete(); m_stall = 0;
        end else if (flush_tb) begin
            pend.delete();
        end else begin
            if (issue_valid && rdy) begin
                e.rt = issue_rt; e.data = issue_result; e.due = cyc + l + 1;
                pend.push_back(e);
            end
            if (issue_valid && !rdy && m_stall < SAT) m_stall++;
        end
        cyc++;
        for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due < cyc) pend.delete(i);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rt = 0; issue_latency = 0; issue_result = '0;
        issue_ra = 0; issue_rb = 0; issue_rc = 0;
        issue_ra_used = 0; issue_rb_used = 0; issue_rc_used = 0;
    endtask

    task automatic drive(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] d);
        idle();
        issue_valid = 1; issue_rt = rt; issue_latency = lat; issue_result = d;
    endtask

    task automatic reset_dut();
        idle(); reset = 1; tick(); tick(); reset = 0; cyc = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        checks++; if (wb_en !== 1'b0) $display("FAIL reset_wb_en got=%b exp=0", wb_en);
        if (wb_en !== 1'b0) errors++;
        checks++; if (wb_rt !== 7'd0 || wb_data !== 128'd0) begin
            errors++; $display("FAIL reset_wb_rt_data got rt=%0d data=%h exp 0", wb_rt, wb_data); end
        checks++; if (inflight !== 4'd0 || stall_cycles !== '0) begin
            errors++; $display("FAIL reset_counters got inflight=%0d stall=%0d exp 0", inflight, stall_cycles); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    endtask

    task automatic test_single();
        bit ee;
        reset_dut();
        for (int k = 0; k < 10; k++) tick();
        drive(7'd5, 3'd2, 128'h1234);
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", issue_ready); end
        tick(); idle();
        for (int k = 11; k <= 15; k++) begin
            ee = (k == 13);
            checks++; if (wb_en !== ee) begin errors++; $display("FAIL single_wb_en cyc=%0d got=%b exp=%b", k, wb_en, ee); end
            if (k == 13) begin
                checks++; if (wb_rt !== 7'd5 || wb_data !== 128'h1234) begin
                    errors++; $display("FAIL single_wb_data got rt=%0d data=%h exp rt=5 data=1234", wb_rt, wb_data); end
            end
            checks++; if (inflight !== ((k <= 13) ? 4'd1 : 4'd0)) begin
                errors++; $display("FAIL single_inflight cyc=%0d got=%0d", k, inflight); end
            tick();
        end
    endtask

    task automatic test_port_conflict();
        reset_dut();
        drive(7'd1, 3'd3, 128'h11); #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL port_c0_ready got=%b exp=1", issue_ready); end
        tick();
        drive(7'd2, 3'd2, 128'h22); #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL port_c1_ready got=%b exp=0", issue_ready); end
        tick(); #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL port_c2_ready got=%b exp=1", issue_ready); end
        tick(); idle();
        for (int k = 3; k <= 6; k++) begin
            checks++; if (wb_en !== (k == 4 || k == 5)) begin errors++; $display("FAIL port_wb_en cyc=%0d got=%b", k, wb_en); end
            if (k == 4 || k == 5) begin
                checks++; if (wb_rt !== ((k == 4) ? 7'd1 : 7'd2)) begin
                    errors++; $display("FAIL port_wb_rt cyc=%0d got=%0d", k, wb_rt); end
            end
            tick();
        end
        checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL port_stall got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_raw();
        reset_dut();
        drive(7'd9, 3'd4, 128'h99); tick();
        drive(7'd20, 3'd0, 128'h2020); issue_ra = 7'd9; issue_ra_used = 1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_ready cyc=%0d got=%b exp=0", k, issue_ready); end
            if (k == 5) begin
                checks++; if (wb_en !== 1'b1 || wb_rt !== 7'd9) begin
                    errors++; $display("FAIL raw_wb9 got en=%b rt=%0d exp en=1 rt=9", wb_en, wb_rt); end
            end
            tick();
        end
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_accept got=%b exp=1", issue_ready); end
        tick(); idle(); #1;
        checks++; if (wb_en !== 1'b1 || wb_rt !== 7'd20 || wb_data !== 128'h2020) begin
            errors++; $display("FAIL raw_wb20 got en=%b rt=%0d data=%h", wb_en, wb_rt, wb_data); end
        checks++; if (stall_cycles !== 4'd5) begin errors++; $display("FAIL raw_stall got=%0d exp=5", stall_cycles); end
        // Same source, but not actually read: no hazard.
        reset_dut();
        drive(7'd9, 3'd4, 128'h99); tick();
        drive(7'd20, 3'd0, 128'h2020); issue_ra = 7'd9; issue_ra_used = 0; #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_unused_ready got=%b exp=1", issue_ready); end
        tick(); idle();
    endtask

    task automatic test_waw();
        logic [127:0] seen[$];
        int acc_cyc = -1;
        bit took;
        reset_dut();
        drive(7'd3, 3'd5, 128'hAAAA); tick();
        drive(7'd3, 3'd0, 128'hBBBB);
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (wb_en && wb_rt == 7'd3) seen.push_back(wb_data);
            took = issue_valid && issue_ready;
            if (took) acc_cyc = k;
            tick();
            if (took) idle();
        end
        checks++; if (acc_cyc != 7) begin errors++; $display("FAIL waw_accept_cycle got=%0d exp=7", acc_cyc); end
        checks++; if (seen.size() != 2) begin errors++; $display("FAIL waw_write_count got=%0d exp=2", seen.size()); end
        else begin
            checks++; if (seen[0] !== 128'hAAAA || seen[1] !== 128'hBBBB) begin
                errors++; $display("FAIL waw_order got %h,%h exp AAAA,BBBB", seen[0], seen[1]); end
        end
    endtask

    task automatic test_back_to_back_reset();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            drive(7'(10 + k), 3'd7, 128'(k)); #1;
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", k, issue_ready); end
            tick();
        end
        drive(7'd10, 3'd0, 128'h5); tick();
        drive(7'd13, 3'd0, 128'h6); reset = 1; tick(); reset = 0; idle();
        checks++; if (inflight !== 4'd0 || stall_cycles !== '0) begin
            errors++; $display("FAIL midreset_counters got inflight=%0d stall=%0d exp 0", inflight, stall_cycles); end
        for (int k = 5; k < 17; k++) begin
            checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL midreset_wb_en cyc=%0d got=%b exp=0", k, wb_en); end
            tick();
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        drive(7'd30, 3'd7, 128'h30);
        for (int k = 0; k < 30; k++) begin
            #1;
            checks++; if (stall_cycles !== CNT_W'(m_stall)) begin
                errors++; $display("FAIL sat_track cyc=%0d got=%0d exp=%0d", k, stall_cycles, m_stall); end
            tick();
        end
        idle(); #1;
        checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_final got=%0d exp=15", stall_cycles); end
    endtask

`ifdef WB_FLUSH_EN
    task automatic test_flush();
        reset_dut();
        drive(7'd6, 3'd3, 128'h66); tick();
        drive(7'd7, 3'd1, 128'h77); flush_tb = 1; #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
        tick(); flush_tb = 0; idle();
        checks++; if (inflight !== 4'd0 || stall_cycles !== '0) begin
            errors++; $display("FAIL flush_counters got inflight=%0d stall=%0d exp 0", inflight, stall_cycles); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en k=%0d got=%b exp=0", k, wb_en); end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        bit en; logic [6:0] ert; logic [127:0] ed;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 80) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rt = 7'($urandom_range(0, 11));
            issue_latency = 3'($urandom_range(0, 7));
            issue_result = {$urandom(), $urandom(), $urandom(), $urandom()};
            issue_ra = 7'($urandom_range(0, 11)); issue_ra_used = 1'($urandom_range(0, 1));
            issue_rb = 7'($urandom_range(0, 11)); issue_rb_used = 1'($urandom_range(0, 1));
            issue_rc = 7'($urandom_range(0, 11)); issue_rc_used = 1'($urandom_range(0, 1));
            #1;
            m_wb(en, ert, ed);
            checks++; if (issue_ready !== m_ready()) begin
                errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, issue_ready, m_ready()); end
            checks++; if (wb_en !== en) begin errors++; $display("FAIL rnd_wb_en n=%0d got=%b exp=%b", n, wb_en, en); end
            if (en) begin
                checks++; if (wb_rt !== ert || wb_data !== ed) begin
                    errors++; $display("FAIL rnd_wb n=%0d got rt=%0d data=%h exp rt=%0d data=%h", n, wb_rt, wb_data, ert, ed); end
            end
            checks++; if (inflight !== 4'(pend.size())) begin
                errors++; $display("FAIL rnd_inflight n=%0d got=%0d exp=%0d", n, inflight, pend.size()); end
            checks++; if (stall_cycles !== CNT_W'(m_stall)) begin
                errors++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall_cycles, m_stall); end
            tick();
        end
        reset = 0; idle();
    endtask

    initial begin
        reset = 1; flush_tb = 0; idle();
        test_reset();
        test_single();
        test_port_conflict();
        test_raw();
        test_waw();
        test_back_to_back_reset();
        test_saturation();
`ifdef WB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
